// File: rtl/overflow_pkg.sv
// overflow_pkg: shared width defaults, signed-limit helpers and the registered result type
package overflow_pkg;

    localparam int WIDTH_DEFAULT = 4;
    localparam int MAX_WIDTH     = 32;

    typedef struct packed {
        logic [MAX_WIDTH-1:0] sum;
        logic                 cout;
        logic                 of;
    } result_t;

    function automatic logic [MAX_WIDTH-1:0] smax(input int w);
        return (MAX_WIDTH'(1) << (w - 1)) - MAX_WIDTH'(1);
    endfunction

    function automatic logic [MAX_WIDTH-1:0] smin(input int w);
        return MAX_WIDTH'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/overflow_detector_if.sv
// overflow_detector_if: operand/result bundle between a producer and the overflow detector
interface overflow_detector_if
    import overflow_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             clr_sticky;
    logic             out_valid;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             of;
    logic             of_sticky;

    modport master (
        output in_valid, a, b, cin, clr_sticky,
        input  out_valid, sum, cout, of, of_sticky
    );

    modport slave (
        input  in_valid, a, b, cin, clr_sticky,
        output out_valid, sum, cout, of, of_sticky
    );
endinterface

// File: rtl/overflow_add_core.sv
// overflow_add_core: combinational WIDTH+1-bit add with unsigned carry and signed overflow
module overflow_add_core #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             c,
    output logic             overflow
);
    assign {c, s}   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign overflow = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
endmodule

// File: rtl/overflow_detector.sv
// overflow_detector: registered adder with carry, signed overflow and sticky overflow flags.
// Define OVERFLOW_SATURATE_EN to clamp the sum to the signed limit on overflow.
module overflow_detector
    import overflow_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    overflow_detector_if.slave bus
);
    logic [WIDTH-1:0]     s;
    logic [WIDTH-1:0]     sum_n;
    logic                 c;
    logic                 ovf;
    logic                 valid_q;
    logic                 sticky_q;
    result_t              res_q;
    logic [MAX_WIDTH-1:0] unused_sum;

    overflow_add_core #(.WIDTH(WIDTH)) u_core (
        .a        (bus.a),
        .b        (bus.b),
        .cin      (bus.cin),
        .s        (s),
        .c        (c),
        .overflow (ovf)
    );

`ifdef OVERFLOW_SATURATE_EN
    // clamp toward the limit the operands' common sign was heading to
    always_comb sum_n = ovf ? (bus.a[WIDTH-1] ? WIDTH'(smin(WIDTH)) : WIDTH'(smax(WIDTH))) : s;
`else
    // plain wrapped result
    always_comb sum_n = s;
`endif

    // capture accepted results; sticky flag lets a same-cycle overflow beat the clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            sticky_q <= 1'b0;
            res_q    <= '0;
        end else begin
            valid_q  <= bus.in_valid;
            sticky_q <= (sticky_q & ~bus.clr_sticky) | (bus.in_valid & ovf);
            if (bus.in_valid)
                res_q <= '{sum: MAX_WIDTH'(sum_n), cout: c, of: ovf};
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.sum       = res_q.sum[WIDTH-1:0];
    assign bus.cout      = res_q.cout;
    assign bus.of        = res_q.of;
    assign bus.of_sticky = sticky_q;
    assign unused_sum    = res_q.sum >> WIDTH;
endmodule

// File: tb/tb_overflow_detector.sv
// tb_overflow_detector: randomized and directed checks against an integer-arithmetic model
module tb_overflow_detector;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic         ev, ec, eo, est;
    logic [W-1:0] es;

    overflow_detector_if #(.WIDTH(W)) bus ();

    overflow_detector #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic model_reset();
        ev = 0; es = '0; ec = 0; eo = 0; est = 0;
    endtask

    // drive one cycle of inputs and advance the model with plain integer arithmetic
    task automatic cycle(input logic v, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic ic, input logic clr);
        int full, sa, sb, ss;
        logic ovf;
        bus.in_valid = v; bus.a = ia; bus.b = ib; bus.cin = ic; bus.clr_sticky = clr;
        @(posedge clk);
        full = int'(ia) + int'(ib) + int'(ic);
        sa   = (int'(ia) >= (1 << (W - 1))) ? int'(ia) - (1 << W) : int'(ia);
        sb   = (int'(ib) >= (1 << (W - 1))) ? int'(ib) - (1 << W) : int'(ib);
        ss   = sa + sb + int'(ic);
        ovf  = (ss > (1 << (W - 1)) - 1) || (ss < -(1 << (W - 1)));
        ev   = v;
        if (v) begin
            es = W'(full % (1 << W));
`ifdef OVERFLOW_SATURATE_EN
            if (ovf) es = (ss < 0) ? W'(1 << (W - 1)) : W'((1 << (W - 1)) - 1);
`endif
            ec = full >= (1 << W);
            eo = ovf;
        end
        est = clr ? (v && ovf) : (est || (v && ovf));
        #1;
    endtask

    task automatic test_reset();
        bus.in_valid = 1; bus.a = 4'hF; bus.b = 4'h8; bus.cin = 1; bus.clr_sticky = 0;
        #2;
        model_reset();
        checks++;
        if ({bus.out_valid, bus.sum, bus.cout, bus.of, bus.of_sticky} !== {ev, es, ec, eo, est}) begin
            errors++;
            $display("FAIL reset: got v=%b sum=%b c=%b of=%b st=%b, expected v=%b sum=%b c=%b of=%b st=%b",
                     bus.out_valid, bus.sum, bus.cout, bus.of, bus.of_sticky, ev, es, ec, eo, est);
        end
        @(posedge clk); #1;
        checks++;
        if ({bus.out_valid, bus.sum, bus.cout, bus.of, bus.of_sticky} !== {ev, es, ec, eo, est}) begin
            errors++;
            $display("FAIL reset_edge: got v=%b sum=%b c=%b of=%b st=%b, expected v=%b sum=%b c=%b of=%b st=%b",
                     bus.out_valid, bus.sum, bus.cout, bus.of, bus.of_sticky, ev, es, ec, eo, est);
        end
        @(negedge clk);
        rst = 0;
        bus.in_valid = 0;
    endtask

    task automatic test_vectors();
        logic [2*W:0] vec [5];
        vec[0] = {4'b0000, 4'b0000, 1'b0};
        vec[1] = {4'b1111, 4'b1000, 1'b0};
        vec[2] = {4'b0111, 4'b0100, 1'b0};
        vec[3] = {4'b0111, 4'b1101, 1'b0};
        vec[4] = {4'b0111, 4'b0000, 1'b1};
        for (int i = 0; i < 5; i++) begin
            cycle(1, vec[i][2*W:W+1], vec[i][W:1], vec[i][0], 0);
            checks++;
            if ({bus.out_valid, bus.sum, bus.cout, bus.of, bus.of_sticky} !== {ev, es, ec, eo, est}) begin
                errors++;
                $display("FAIL vector%0d: got v=%b sum=%b c=%b of=%b st=%b, expected v=%b sum=%b c=%b of=%b st=%b",
                         i, bus.out_valid, bus.sum, bus.cout, bus.of, bus.of_sticky, ev, es, ec, eo, est);
            end
        end
    endtask

    task automatic test_sticky();
        cycle(1, 4'b0111, 4'b1101, 0, 0);
        cycle(0, 4'b0000, 4'b0000, 0, 1);
        cycle(1, 4'b0111, 4'b0100, 0, 1);
        cycle(1, 4'b0001, 4'b0001, 0, 0);
        checks++;
        if ({bus.out_valid, bus.sum, bus.cout, bus.of, bus.of_sticky} !== {ev, es, ec, eo, est}) begin
            errors++;
            $display("FAIL sticky_hold: got v=%b sum=%b c=%b of=%b st=%b, expected v=%b sum=%b c=%b of=%b st=%b",
                     bus.out_valid, bus.sum, bus.cout, bus.of, bus.of_sticky, ev, es, ec, eo, est);
        end
        cycle(1, 4'b0010, 4'b0001, 0, 1);
        checks++;
        if ({bus.out_valid, bus.sum, bus.cout, bus.of, bus.of_sticky} !== {ev, es, ec, eo, est}) begin
            errors++;
            $display("FAIL sticky_clear: got v=%b sum=%b c=%b of=%b st=%b, expected v=%b sum=%b c=%b of=%b st=%b",
                     bus.out_valid, bus.sum, bus.cout, bus.of, bus.of_sticky, ev, es, ec, eo, est);
        end
        cycle(1, 4'b1000, 4'b1000, 0, 1);
        checks++;
        if ({bus.out_valid, bus.sum, bus.cout, bus.of, bus.of_sticky} !== {ev, es, ec, eo, est}) begin
            errors++;
            $display("FAIL sticky_clear_vs_set: got v=%b sum=%b c=%b of=%b st=%b, expected v=%b sum=%b c=%b of=%b st=%b",
                     bus.out_valid, bus.sum, bus.cout, bus.of, bus.of_sticky, ev, es, ec, eo, est);
        end
    endtask

    task automatic test_hold();
        cycle(1, 4'b0101, 4'b0110, 1, 1);
        for (int i = 0; i < 3; i++) begin
            cycle(0, W'($urandom), W'($urandom), 1'($urandom), 0);
            checks++;
            if ({bus.out_valid, bus.sum, bus.cout, bus.of, bus.of_sticky} !== {ev, es, ec, eo, est}) begin
                errors++;
                $display("FAIL hold%0d: got v=%b sum=%b c=%b of=%b st=%b, expected v=%b sum=%b c=%b of=%b st=%b",
                         i, bus.out_valid, bus.sum, bus.cout, bus.of, bus.of_sticky, ev, es, ec, eo, est);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            cycle(1, W'($urandom), W'($urandom), 1'($urandom), 0);
            checks++;
            if ({bus.out_valid, bus.sum, bus.cout, bus.of, bus.of_sticky} !== {ev, es, ec, eo, est}) begin
                errors++;
                $display("FAIL back_to_back%0d: got v=%b sum=%b c=%b of=%b st=%b, expected v=%b sum=%b c=%b of=%b st=%b",
                         i, bus.out_valid, bus.sum, bus.cout, bus.of, bus.of_sticky, ev, es, ec, eo, est);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), W'($urandom), W'($urandom), 1'($urandom),
                  1'($urandom_range(0, 7) == 0));
            checks++;
            if ({bus.out_valid, bus.sum, bus.cout, bus.of, bus.of_sticky} !== {ev, es, ec, eo, est}) begin
                errors++;
                $display("FAIL random%0d: got v=%b sum=%b c=%b of=%b st=%b, expected v=%b sum=%b c=%b of=%b st=%b",
                         i, bus.out_valid, bus.sum, bus.cout, bus.of, bus.of_sticky, ev, es, ec, eo, est);
            end
        end
    endtask

    task automatic test_async_reset();
        cycle(1, 4'b0111, 4'b0100, 0, 0);
        bus.a = 4'b1111; bus.b = 4'b1000;
        #2;
        rst = 1;
        #1;
        model_reset();
        checks++;
        if ({bus.out_valid, bus.sum, bus.cout, bus.of, bus.of_sticky} !== {ev, es, ec, eo, est}) begin
            errors++;
            $display("FAIL async_reset: got v=%b sum=%b c=%b of=%b st=%b, expected v=%b sum=%b c=%b of=%b st=%b",
                     bus.out_valid, bus.sum, bus.cout, bus.of, bus.of_sticky, ev, es, ec, eo, est);
        end
        @(posedge clk); #1;
        checks++;
        if ({bus.out_valid, bus.sum, bus.cout, bus.of, bus.of_sticky} !== {ev, es, ec, eo, est}) begin
            errors++;
            $display("FAIL reset_discard: got v=%b sum=%b c=%b of=%b st=%b, expected v=%b sum=%b c=%b of=%b st=%b",
                     bus.out_valid, bus.sum, bus.cout, bus.of, bus.of_sticky, ev, es, ec, eo, est);
        end
        @(negedge clk);
        rst = 0;
        cycle(0, 4'b0111, 4'b0111, 1, 0);
        checks++;
        if ({bus.out_valid, bus.sum, bus.cout, bus.of, bus.of_sticky} !== {ev, es, ec, eo, est}) begin
            errors++;
            $display("FAIL post_reset_idle: got v=%b sum=%b c=%b of=%b st=%b, expected v=%b sum=%b c=%b of=%b st=%b",
                     bus.out_valid, bus.sum, bus.cout, bus.of, bus.of_sticky, ev, es, ec, eo, est);
        end
        cycle(1, 4'b0111, 4'b0000, 1, 0);
        checks++;
        if ({bus.out_valid, bus.sum, bus.cout, bus.of, bus.of_sticky} !== {ev, es, ec, eo, est}) begin
            errors++;
            $display("FAIL post_reset_op: got v=%b sum=%b c=%b of=%b st=%b, expected v=%b sum=%b c=%b of=%b st=%b",
                     bus.out_valid, bus.sum, bus.cout, bus.of, bus.of_sticky, ev, es, ec, eo, est);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_sticky();
        test_hold();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/overflow_detector.md
OVERFLOW_DETECTOR -- requirements
Module: overflow_detector

Interface
- REQ-001 Parameter WIDTH, default 4, operand/sum width in bits; legal range 2..32.
- REQ-002 clk  input  1  single clock; all state updates on rising edge.
- REQ-003 rst  input  1  reset, asynchronous, active-high.
- REQ-004 in_valid  input  1  operands valid this cycle.
- REQ-005 a  input  WIDTH  operand A, two's complement or unsigned.
- REQ-006 b  input  WIDTH  operand B, two's complement or unsigned.
- REQ-007 cin  input  1  carry-in.
- REQ-008 clr_sticky  input  1  synchronous clear of of_sticky.
- REQ-009 out_valid  output  1  registered result valid.
- REQ-010 sum  output  WIDTH  registered sum.
- REQ-011 cout  output  1  registered unsigned carry-out.
- REQ-012 of  output  1  registered signed-overflow flag.
- REQ-013 of_sticky  output  1  set by any accepted overflowing add; held until cleared.

Function
- REQ-014 Raw result {c, s} = a + b + cin, computed at WIDTH+1 bits; no truncation before carry extraction.
- REQ-015 Signed overflow SHALL be (a[MSB] == b[MSB]) AND (s[MSB] != a[MSB]); cin contributes only through s.
- REQ-016 Latency exactly 1 cycle: when in_valid=1 at an edge, sum/cout/of update at that edge and out_valid=1 for that cycle.
- REQ-017 When in_valid=0 at an edge: out_valid=0; sum, cout and of hold their previous values.
- REQ-018 of_sticky next = clr_sticky ? (in_valid AND overflow) : (of_sticky OR (in_valid AND overflow)); a new overflow in the clear cycle wins.
- REQ-019 Back-to-back in_valid SHALL be accepted every cycle with no stall; no backpressure.
- REQ-020 cout is the unsigned carry and is never modified by saturation.

Reset
- REQ-021 While rst=1: out_valid=0, sum=0, cout=0, of=0, of_sticky=0, applied immediately, independent of clk.
- REQ-022 An operation presented in the cycle rst deasserts SHALL NOT be accepted if rst is still high at that edge; reset mid-stream discards the pending result.

Configuration
- REQ-023 Macro OVERFLOW_SATURATE_EN: when defined, on signed overflow sum SHALL be the signed limit (0 1..1 if a[MSB]=0, 1 0..0 if a[MSB]=1); of still reports 1.
- REQ-024 Without OVERFLOW_SATURATE_EN, sum SHALL be the wrapped WIDTH-bit result s.

Structure
- REQ-025 Package overflow_pkg SHALL hold WIDTH default, signed max/min constant functions and the result struct {sum, cout, of}.
- REQ-026 One combinational sub-module overflow_add_core (a, b, cin -> s, c, overflow) SHALL be instantiated; registers, sticky and saturation live in overflow_detector.

Verification (WIDTH=4, without saturation unless stated)
- REQ-027 a=0000 b=0000 cin=0 -> sum=0000 cout=0 of=0 one cycle later.
- REQ-028 a=1111 b=1000 cin=0 -> sum=0111 cout=1 of=1, of_sticky=1; with OVERFLOW_SATURATE_EN sum=1000.
- REQ-029 a=0111 b=0100 cin=0 -> sum=1011 cout=0 of=1; with OVERFLOW_SATURATE_EN sum=0111.
- REQ-030 a=0111 b=1101 cin=0 -> sum=0100 cout=1 of=0; of_sticky stays 1 until clr_sticky pulse, then 0.
- REQ-031 a=0111 b=0000 cin=1 -> sum=1000 cout=0 of=1 (carry-in-induced overflow).
- REQ-032 Assert rst between clock edges during a valid stream -> all outputs 0 immediately; in_valid=0 cycles hold sum unchanged with out_valid=0.
